// File: rtl/node_inject_queue.sv
// Local injection FIFO feeding one router local input port.
// Presents the head flit (all-zero when idle), pops on portl_ack and tracks head wait time.
module node_inject_queue #(
  parameter int FLIT_W        = 144,
  parameter int DEPTH         = 4,
  parameter int PTR_W         = 2,
  parameter int WAIT_W        = 8,
  parameter int STARVE_THRESH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [FLIT_W-1:0] portl_co,
  input  logic              portl_ack,
  output logic [PTR_W:0]    count,
  output logic              starve,
  output logic              ovf_err
);

  localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ovf_q;
  logic              full;
  logic              empty;
  logic              enq;
  logic              deq;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign enq   = in_valid & ~full;
  assign deq   = portl_ack & ~empty;

  // Outputs come from registered state only, so reset clears them without a clock edge.
  assign in_ready = ~full;
  assign portl_co = empty ? '0 : mem[rd_ptr];
  assign count    = count_q;
  assign starve   = (int'(wait_cnt) >= STARVE_THRESH);
  assign ovf_err  = ovf_q;

  // Storage is not reset: stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      wait_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A fresh head (or no head) starts waiting from zero.
      if (empty || deq) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (in_valid && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_node_inject_queue.sv
// Self-checking bench for node_inject_queue: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_node_inject_queue;

  localparam int FLIT_W        = 144;
  localparam int DEPTH         = 4;
  localparam int PTR_W         = 2;
  localparam int WAIT_W        = 8;
  localparam int STARVE_THRESH = 64;
  localparam int WAIT_MAX      = (1 << WAIT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [FLIT_W-1:0] in_flit = '0;
  logic              portl_ack = 1'b0;
  logic              in_ready;
  logic [FLIT_W-1:0] portl_co;
  logic [PTR_W:0]    count;
  logic              starve;
  logic              ovf_err;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [FLIT_W-1:0] model_q[$];
  int                model_wait = 0;
  bit                model_ovf = 1'b0;

  node_inject_queue #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .PTR_W(PTR_W),
    .WAIT_W(WAIT_W), .STARVE_THRESH(STARVE_THRESH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
    .in_ready(in_ready), .portl_co(portl_co), .portl_ack(portl_ack),
    .count(count), .starve(starve), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [FLIT_W-1:0] act,
                             input logic [FLIT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] model_head();
    return (model_q.size() != 0) ? model_q[0] : '0;
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_wait = 0;
    model_ovf  = 1'b0;
  endtask

  // One clock of the reference behaviour, applied to pre-edge model state.
  task automatic model_step(input logic v, input logic [FLIT_W-1:0] f, input logic ack);
    bit is_full, do_enq, do_deq;
    if (!rst) begin
      model_reset();
      return;
    end
    is_full = (model_q.size() == DEPTH);
    do_enq  = v && !is_full;
    do_deq  = ack && (model_q.size() != 0);
    if (v && is_full) model_ovf = 1'b1;
    if (model_q.size() == 0 || do_deq) model_wait = 0;
    else if (model_wait < WAIT_MAX) model_wait++;
    if (do_deq) void'(model_q.pop_front());
    if (do_enq) model_q.push_back(f);
  endtask

  task automatic compare_model();
    checkOutput("portl_co", portl_co, model_head());
    checkOutput("count", FLIT_W'(count), FLIT_W'(model_q.size()));
    checkOutput("in_ready", FLIT_W'(in_ready), FLIT_W'(model_q.size() != DEPTH));
    checkOutput("starve", FLIT_W'(starve), FLIT_W'(model_wait >= STARVE_THRESH));
    checkOutput("ovf_err", FLIT_W'(ovf_err), FLIT_W'(model_ovf));
  endtask

  always @(negedge clk) begin
    if (cmp_en) compare_model();
  end

  task automatic applyStimulus(input logic v, input logic [FLIT_W-1:0] f, input logic ack);
    in_valid  = v;
    in_flit   = f;
    portl_ack = ack;
    @(posedge clk);
    model_step(v, f, ack);
    #1;
    in_valid  = 1'b0;
    in_flit   = '0;
    portl_ack = 1'b0;
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input int idx);
    logic [FLIT_W-1:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), 16'(idx)};
    return r | FLIT_W'(1);
  endfunction

  task automatic drain();
    int guard = 0;
    while (model_q.size() != 0 && guard < 20) begin
      applyStimulus(1'b0, '0, 1'b1);
      guard++;
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL timeout reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [FLIT_W-1:0] lit;
    logic [FLIT_W-1:0] f[8];
    logic [FLIT_W-1:0] sent[$];
    logic [FLIT_W-1:0] got[$];
    logic [FLIT_W-1:0] fl;
    int pushes, pops, iter, sz, r;
    bit p, q, push_ok, pop_ok;

    model_reset();
    cmp_en = 1'b1;

    // Reset then idle
    applyStimulus(1'b1, mk_flit(100), 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rst_co", portl_co, '0);
    checkOutput("rst_count", FLIT_W'(count), FLIT_W'(0));
    checkOutput("rst_in_ready", FLIT_W'(in_ready), FLIT_W'(1));
    checkOutput("rst_starve", FLIT_W'(starve), FLIT_W'(0));
    checkOutput("rst_ovf", FLIT_W'(ovf_err), FLIT_W'(0));

    // Single flit
    lit = 144'h0aaaaaaaaaabcdef0123456789abcdef1857;
    applyStimulus(1'b1, lit, 1'b0);
    checkOutput("single_head", portl_co, lit);
    checkOutput("single_count", FLIT_W'(count), FLIT_W'(1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("single_drain_co", portl_co, '0);
    checkOutput("single_drain_count", FLIT_W'(count), FLIT_W'(0));

    // Fill and overflow
    for (int i = 0; i < 5; i++) f[i] = mk_flit(i + 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, f[i], 1'b0);
    checkOutput("fill_count", FLIT_W'(count), FLIT_W'(4));
    checkOutput("fill_in_ready", FLIT_W'(in_ready), FLIT_W'(0));
    applyStimulus(1'b1, f[4], 1'b0);
    checkOutput("ovf_set", FLIT_W'(ovf_err), FLIT_W'(1));
    checkOutput("ovf_count", FLIT_W'(count), FLIT_W'(4));
    for (int i = 0; i < 4; i++) begin
      checkOutput("fill_order", portl_co, f[i]);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("fill_empty_co", portl_co, '0);

    // Simultaneous push/pop at count=2 and at full
    for (int i = 0; i < 3; i++) f[i] = mk_flit(40 + i);
    applyStimulus(1'b1, f[0], 1'b0);
    applyStimulus(1'b1, f[1], 1'b0);
    applyStimulus(1'b1, f[2], 1'b1);
    checkOutput("pp_count", FLIT_W'(count), FLIT_W'(2));
    checkOutput("pp_head_b", portl_co, f[1]);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pp_head_c", portl_co, f[2]);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      f[i] = mk_flit(50 + i);
      applyStimulus(1'b1, f[i], 1'b0);
    end
    applyStimulus(1'b1, mk_flit(59), 1'b1);
    checkOutput("full_pp_count", FLIT_W'(count), FLIT_W'(3));
    checkOutput("full_pp_head", portl_co, f[1]);
    drain();

    // Wrap-around with occupancy held in 1..3
    pushes = 0; pops = 0; iter = 0;
    while (pops < 10 && iter < 100) begin
      sz = model_q.size();
      push_ok = (pushes < 10) && (sz < 3);
      pop_ok  = (sz >= 2) || (pushes == 10 && sz >= 1);
      r = $urandom_range(0, 2);
      p = 1'b0; q = 1'b0;
      if (r == 0) p = push_ok;
      else if (r == 1) q = pop_ok;
      else begin
        p = (pushes < 10) && (sz >= 1);
        q = p;
      end
      if (!p && !q) begin
        if (push_ok) p = 1'b1;
        else if (pop_ok) q = 1'b1;
      end
      fl = '0;
      if (q) begin
        got.push_back(portl_co);
        pops++;
      end
      if (p) begin
        fl = mk_flit(20 + pushes);
        sent.push_back(fl);
        pushes++;
      end
      applyStimulus(p, fl, q);
      iter++;
    end
    checkOutput("wrap_pops", FLIT_W'(pops), FLIT_W'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < got.size() && i < sent.size()) checkOutput("wrap_order", got[i], sent[i]);
    end

    // Random traffic with varying backpressure
    for (int i = 0; i < 300; i++) begin
      p = ($urandom_range(0, 3) != 0);
      q = ($urandom_range(0, (i < 150) ? 3 : 1) == 0);
      applyStimulus(p, p ? mk_flit(200 + i) : '0, q);
    end
    drain();

    // Starvation and saturation of the wait counter
    fl = mk_flit(77);
    applyStimulus(1'b1, fl, 1'b0);
    for (int k = 1; k <= 330; k++) begin
      applyStimulus(1'b0, '0, 1'b0);
      if (k == 63) checkOutput("starve_63", FLIT_W'(starve), FLIT_W'(0));
      if (k == 64) checkOutput("starve_64", FLIT_W'(starve), FLIT_W'(1));
      if (k == 300) checkOutput("starve_sat", FLIT_W'(starve), FLIT_W'(1));
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("starve_clear", FLIT_W'(starve), FLIT_W'(0));
    checkOutput("starve_count", FLIT_W'(count), FLIT_W'(0));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("empty_ack_count", FLIT_W'(count), FLIT_W'(0));
    checkOutput("empty_ack_co", portl_co, '0);
    checkOutput("empty_ack_ready", FLIT_W'(in_ready), FLIT_W'(1));

    // Asynchronous reset between edges
    applyStimulus(1'b1, mk_flit(90), 1'b0);
    applyStimulus(1'b1, mk_flit(91), 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checkOutput("async_co", portl_co, '0);
    checkOutput("async_count", FLIT_W'(count), FLIT_W'(0));
    checkOutput("async_starve", FLIT_W'(starve), FLIT_W'(0));
    checkOutput("async_ready", FLIT_W'(in_ready), FLIT_W'(1));
    checkOutput("async_ovf", FLIT_W'(ovf_err), FLIT_W'(0));
    applyStimulus(1'b1, mk_flit(92), 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("no_replay_count", FLIT_W'(count), FLIT_W'(0));

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
